// File: rtl/CpuParams.sv
`default_nettype none
// ============================================================================
// Package : CpuParams
// Shared CPU widths and the fetch queue entry type.
// Rev     : 1.0
// ============================================================================
package CpuParams;

    localparam int ADDR_WIDTH = 32;
    localparam int WORD_WIDTH = 32;
    localparam int WORD_SIZE  = WORD_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } fetch_entry_t;

endpackage : CpuParams
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue_mem
// DEPTH-entry storage array, one write port and one asynchronous read port.
// Rev    : 1.0
// ============================================================================
module fetch_queue_mem
    import CpuParams::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  entry_t                   i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output entry_t                   o_rdata
);

    // Contents are intentionally left unreset; validity is tracked by the pointers.
    entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : fetch_queue_mem
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : fetch_queue
// Circular instruction fetch queue between IFU and decode.
// Optional same-cycle empty-queue bypass under macro FETCH_QUEUE_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
module fetch_queue
    import CpuParams::*;
#(
    parameter int ADDR_WIDTH = CpuParams::ADDR_WIDTH,
    parameter int WORD_WIDTH = CpuParams::WORD_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    input  logic [WORD_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [WORD_WIDTH-1:0]  out_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0] data;
    } entry_t;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic   w_empty;
    logic   w_bypass;
    logic   w_push;
    logic   w_pop;
    entry_t w_wdata;
    entry_t w_head;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != c_depth);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with decode ready: hand the word straight through, never stored.
    assign w_bypass  = w_empty && in_valid && out_ready && !flush;
    assign out_valid = !w_empty || w_bypass;
    assign out_addr  = w_bypass ? in_addr : w_head.addr;
    assign out_data  = w_bypass ? in_data : w_head.data;
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !w_empty;
    assign out_addr  = w_head.addr;
    assign out_data  = w_head.data;
`endif

    assign w_push = in_valid && in_ready && !flush && !w_bypass;
    assign w_pop  = !w_empty && out_ready && !flush;

    assign w_wdata.addr = in_addr;
    assign w_wdata.data = in_data;
    assign count        = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_queue
// Scoreboard bench for fetch_queue (DEPTH = 4, 32-bit address and word).
// Rev    : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // Expected entries as {addr, data}, oldest at the front.
    logic [63:0] sb_q [$];

    fetch_queue #(
        .ADDR_WIDTH (32),
        .WORD_WIDTH (32),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge and hold for one full cycle.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            n++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    // Scoreboard: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        int  n;
        logic byp;
        if (!reset) begin
            sb_q.delete();
        end else begin
            n   = sb_q.size();
            byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (n == 0) && in_valid && out_ready && !flush;
`endif
            check("count", 64'(count), 64'(n));
            check("in_ready", 64'(in_ready), 64'(n != DEPTH));
            if (byp) begin
                check("byp_valid", 64'(out_valid), 64'd1);
                check("byp_entry", {out_addr, out_data}, {in_addr, in_data});
            end else begin
                check("out_valid", 64'(out_valid), 64'(n != 0));
                if (n != 0) begin
                    check("head", {out_addr, out_data}, sb_q[0]);
                end
            end
            if (flush) begin
                sb_q.delete();
            end else if (!byp) begin
                if (n != 0 && out_ready) begin
                    void'(sb_q.pop_front());
                end
                if (in_valid && n != DEPTH) begin
                    sb_q.push_back({in_addr, in_data});
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Two words back to back, decode always ready.
        drive(1'b1, 32'h100, 32'h11, 1'b1, 1'b0);
        drive(1'b1, 32'h104, 32'h22, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle();

        // Overfill with decode stalled: fifth word must be dropped.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
        end
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("empty_after_pop", 64'(count), 64'd0);
        idle();

        // Steady push+pop at occupancy 2, pointers wrap several times.
        drive(1'b1, 32'h300, 32'h30, 1'b0, 1'b0);
        drive(1'b1, 32'h304, 32'h31, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 1'b1, 1'b0);
        end
        check("steady_count", 64'(count), 64'd2);
        drain();

        // Flush at occupancy 3 while a word is offered.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 32'h50 + 32'(i), 1'b0, 1'b0);
        end
        drive(1'b1, 32'h999, 32'hDEAD, 1'b0, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h600, 32'h77, 1'b0, 1'b0);
        drain();

        // Asynchronous reset mid-stream at occupancy 2.
        drive(1'b1, 32'h700, 32'h70, 1'b0, 1'b0);
        drive(1'b1, 32'h704, 32'h71, 1'b0, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b1, 32'h800, 32'h55, 1'b0, 1'b0);
        check("post_rst_push", 64'(count), 64'd1);
        drain();
        idle();

        // Word offered to an empty queue with decode ready.
        in_valid  = 1'b1;
        in_addr   = 32'h900;
        in_data   = 32'hAB;
        out_ready = 1'b1;
        flush     = 1'b0;
        #2;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("bypass_valid", 64'(out_valid), 64'd1);
        check("bypass_data", 64'(out_data), 64'hAB);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("bypass_count", 64'(count), 64'd0);
`else
        check("no_bypass_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("no_bypass_count", 64'(count), 64'd1);
        check("no_bypass_data", 64'(out_data), 64'hAB);
`endif
        drain();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
